// File: rtl/ibex_prefetch_buffer_multi.sv
// Instruction prefetch buffer with up to NumReqs fetches in flight and a
// FetchDepth-entry FIFO of {addr, rdata}. Branches flush the FIFO and mark
// every in-flight response for discard, so fetching restarts immediately.
module ibex_prefetch_buffer_multi #(
  parameter int unsigned NumReqs    = 2,
  parameter int unsigned FetchDepth = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  output logic        busy_o
);
  localparam int unsigned CW = $clog2(NumReqs + 1);
  localparam int unsigned PW = (FetchDepth > 1) ? $clog2(FetchDepth) : 1;
  localparam int unsigned FW = $clog2(FetchDepth + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
  } entry_t;

  entry_t        fifo_q [FetchDepth];
  entry_t        fifo_d [FetchDepth];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] os_cnt_q, os_cnt_d, disc_cnt_q, disc_cnt_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d, resp_addr_q, resp_addr_d;
  logic          req_pending_q, req_pending_d;
  logic [31:0]   os_w, live_w, fill_w, req_addr;
  logic          can_issue, req_int, gnt, rv, push, pop, head_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FetchDepth - 1) ? '0 : p + PW'(1);
  endfunction

  // Issue decision: a new request only if its response is guaranteed a FIFO slot
  always_comb begin
    head_valid = (fifo_cnt_q != '0);
    os_w       = 32'(os_cnt_q);
    live_w     = 32'(os_cnt_q) - 32'(disc_cnt_q);
    fill_w     = branch_i ? 32'd0 : 32'(fifo_cnt_q);
    can_issue  = req_i && (os_w < NumReqs) && (fill_w + live_w < FetchDepth);
    // A raised request is held until granted, even if req_i drops
    req_int    = !rst_i && (can_issue || req_pending_q);
    req_addr   = branch_i ? {addr_i[31:2], 2'b00} : fetch_addr_q;
    gnt        = req_int && instr_gnt_i;
    // An rvalid with nothing outstanding is a protocol error and is ignored
    rv         = instr_rvalid_i && (os_cnt_q != '0);
    push       = rv && !branch_i && (disc_cnt_q == '0);
    pop        = head_valid && ready_i;
  end

  // Next-state for counters, addresses and FIFO
  always_comb begin
    os_cnt_d      = os_cnt_q;
    disc_cnt_d    = disc_cnt_q;
    fetch_addr_d  = fetch_addr_q;
    resp_addr_d   = resp_addr_q;
    req_pending_d = req_int && !instr_gnt_i;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;

    if (gnt && !rv)      os_cnt_d = os_cnt_q + CW'(1);
    else if (!gnt && rv) os_cnt_d = os_cnt_q - CW'(1);

    // A pending-but-ungranted request follows the branch target
    if (branch_i) fetch_addr_d = req_addr;
    if (gnt)      fetch_addr_d = req_addr + 32'd4;

    // Everything in flight before the branch is dropped; a same-cycle grant is not
    if (branch_i)                     disc_cnt_d = os_cnt_q - CW'(rv);
    else if (rv && disc_cnt_q != '0)  disc_cnt_d = disc_cnt_q - CW'(1);

    // First word after a branch keeps the halfword address, later ones are word aligned
    if (branch_i)  resp_addr_d = addr_i;
    else if (push) resp_addr_d = {resp_addr_q[31:2], 2'b00} + 32'd4;

    if (branch_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = {resp_addr_q, instr_rdata_i};
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      fifo_cnt_d = fifo_cnt_q + FW'(1);
      else if (!push && pop) fifo_cnt_d = fifo_cnt_q - FW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      os_cnt_q      <= '0;
      disc_cnt_q    <= '0;
      fetch_addr_q  <= '0;
      resp_addr_q   <= '0;
      req_pending_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      for (int unsigned i = 0; i < FetchDepth; i++) fifo_q[i] <= '0;
    end else begin
      os_cnt_q      <= os_cnt_d;
      disc_cnt_q    <= disc_cnt_d;
      fetch_addr_q  <= fetch_addr_d;
      resp_addr_q   <= resp_addr_d;
      req_pending_q <= req_pending_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_q        <= fifo_d;
    end
  end

  assign valid_o      = head_valid;
  assign rdata_o      = head_valid ? fifo_q[rd_ptr_q].rdata : '0;
  assign addr_o       = head_valid ? fifo_q[rd_ptr_q].addr  : '0;
  assign instr_req_o  = req_int;
  assign instr_addr_o = rst_i ? '0 : req_addr;
  assign busy_o       = (os_cnt_q != '0) || req_int;

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) instr_rvalid_i |-> (os_cnt_q != '0));

endmodule

// File: tb/tb_ibex_prefetch_buffer_multi.sv
// Directed bench for ibex_prefetch_buffer_multi (NumReqs=2, FetchDepth=3).
// Inputs change at negedge; outputs are sampled 1ns later, well away from posedge.
module tb_ibex_prefetch_buffer_multi;
  logic        clk_i = 1'b0, rst_i, req_i, branch_i, ready_i;
  logic [31:0] addr_i, instr_rdata_i;
  logic        instr_gnt_i, instr_rvalid_i;
  logic        valid_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;

  typedef struct { logic [31:0] a; int due; } rsp_t;
  rsp_t q[$];
  int   cyc, lat, grants, ncmp, nfail;
  bit   gnt_en, rv_hold;

  ibex_prefetch_buffer_multi #(.NumReqs(2), .FetchDepth(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_rvalid_i(instr_rvalid_i), .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory side: grant when enabled, answer in order 'lat' cycles after grant
  task automatic settle();
    instr_gnt_i    = gnt_en;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    if (!rv_hold && !rst_i && q.size() > 0) begin
      if (q[0].due <= cyc) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = dat(q[0].a);
      end
    end
    #1;
  endtask

  task automatic advance();
    if (instr_rvalid_i) void'(q.pop_front());
    if (instr_req_o && instr_gnt_i) begin
      q.push_back('{instr_addr_o, cyc + lat});
      grants++;
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; ready_i = 1'b0;
    gnt_en = 1'b0; rv_hold = 1'b0; lat = 1;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0; cyc = 0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b1; gnt_en = 1'b1; rv_hold = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      settle();
      if (!busy_o && !valid_o) done = 1'b1;
      advance();
    end
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL drain_timeout: busy_o=%0b valid_o=%0b, required both 0", busy_o, valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h1234; ready_i = 1'b1;
    gnt_en = 1'b1; rv_hold = 1'b1; lat = 1; q.delete();
    @(negedge clk_i);
    settle();
    ncmp++; if (instr_req_o !== 1'b0) begin nfail++; $display("FAIL rst_req: got %0b want 0", instr_req_o); end
    ncmp++; if (instr_addr_o !== 32'h0) begin nfail++; $display("FAIL rst_iaddr: got %h want 0", instr_addr_o); end
    ncmp++; if (valid_o !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %0b want 0", valid_o); end
    ncmp++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %0b want 0", busy_o); end
    ncmp++; if (rdata_o !== 32'h0 || addr_o !== 32'h0) begin nfail++; $display("FAIL rst_head: got %h/%h want 0/0", rdata_o, addr_o); end
    do_reset();
    settle();
    ncmp++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin nfail++; $display("FAIL idle_after_rst: req %0b busy %0b want 0 0", instr_req_o, busy_o); end
    advance();
  endtask

  task automatic test_stream();
    gnt_en = 1'b1; lat = 1; ready_i = 1'b1; rv_hold = 1'b0;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100; settle();
    ncmp++; if (instr_req_o !== 1'b1) begin nfail++; $display("FAIL stream_req0: got %0b want 1", instr_req_o); end
    ncmp++; if (instr_addr_o !== 32'h100) begin nfail++; $display("FAIL stream_ia0: got %h want 100", instr_addr_o); end
    advance();
    branch_i = 1'b0; settle();
    ncmp++; if (instr_addr_o !== 32'h104) begin nfail++; $display("FAIL stream_ia1: got %h want 104", instr_addr_o); end
    ncmp++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin nfail++; $display("FAIL stream_c1: busy %0b valid %0b want 1 0", busy_o, valid_o); end
    advance();
    settle();
    ncmp++; if (instr_addr_o !== 32'h108) begin nfail++; $display("FAIL stream_ia2: got %h want 108", instr_addr_o); end
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h100) begin nfail++; $display("FAIL stream_head0: valid %0b addr %h want 1 100", valid_o, addr_o); end
    ncmp++; if (rdata_o !== dat(32'h100)) begin nfail++; $display("FAIL stream_data0: got %h want %h", rdata_o, dat(32'h100)); end
    advance();
    settle();
    ncmp++; if (addr_o !== 32'h104 || rdata_o !== dat(32'h104)) begin nfail++; $display("FAIL stream_head1: got %h/%h want 104/%h", addr_o, rdata_o, dat(32'h104)); end
    advance();
    req_i = 1'b0; settle();
    ncmp++; if (addr_o !== 32'h108 || rdata_o !== dat(32'h108)) begin nfail++; $display("FAIL stream_head2: got %h/%h want 108/%h", addr_o, rdata_o, dat(32'h108)); end
    ncmp++; if (instr_req_o !== 1'b0) begin nfail++; $display("FAIL stream_req_off: got %0b want 0", instr_req_o); end
    advance();
    drain();
  endtask

  task automatic test_backpressure();
    gnt_en = 1'b1; lat = 1; ready_i = 1'b0; rv_hold = 1'b0; grants = 0;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h400; settle();
    ncmp++; if (instr_addr_o !== 32'h400) begin nfail++; $display("FAIL bp_ia0: got %h want 400", instr_addr_o); end
    advance();
    branch_i = 1'b0; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h404) begin nfail++; $display("FAIL bp_ia1: req %0b addr %h want 1 404", instr_req_o, instr_addr_o); end
    advance();
    settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h408) begin nfail++; $display("FAIL bp_ia2: req %0b addr %h want 1 408", instr_req_o, instr_addr_o); end
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h400) begin nfail++; $display("FAIL bp_head_c2: valid %0b addr %h want 1 400", valid_o, addr_o); end
    advance();
    settle();
    ncmp++; if (instr_req_o !== 1'b0) begin nfail++; $display("FAIL bp_full_c3: req %0b want 0", instr_req_o); end
    advance();
    settle();
    ncmp++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin nfail++; $display("FAIL bp_idle: req %0b busy %0b want 0 0", instr_req_o, busy_o); end
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h400) begin nfail++; $display("FAIL bp_hold: valid %0b addr %h want 1 400", valid_o, addr_o); end
    ncmp++; if (grants !== 3) begin nfail++; $display("FAIL bp_grants3: got %0d want 3", grants); end
    advance();
    ready_i = 1'b1; settle();
    ncmp++; if (instr_req_o !== 1'b0) begin nfail++; $display("FAIL bp_pop_cycle: req %0b want 0", instr_req_o); end
    advance();
    ready_i = 1'b0; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40C) begin nfail++; $display("FAIL bp_refill: req %0b addr %h want 1 40c", instr_req_o, instr_addr_o); end
    ncmp++; if (addr_o !== 32'h404) begin nfail++; $display("FAIL bp_head_after_pop: got %h want 404", addr_o); end
    advance();
    settle();
    ncmp++; if (instr_req_o !== 1'b0) begin nfail++; $display("FAIL bp_one_only: req %0b want 0", instr_req_o); end
    advance();
    settle();
    ncmp++; if (grants !== 4 || busy_o !== 1'b0) begin nfail++; $display("FAIL bp_grants4: grants %0d busy %0b want 4 0", grants, busy_o); end
    advance();
    drain();
  endtask

  task automatic test_branch_discard();
    gnt_en = 1'b1; lat = 1; ready_i = 1'b1; rv_hold = 1'b1;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h10C; settle();
    ncmp++; if (instr_addr_o !== 32'h10C) begin nfail++; $display("FAIL disc_ia0: got %h want 10c", instr_addr_o); end
    advance();
    branch_i = 1'b0; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h110) begin nfail++; $display("FAIL disc_ia1: req %0b addr %h want 1 110", instr_req_o, instr_addr_o); end
    advance();
    branch_i = 1'b1; addr_i = 32'h200; settle();
    ncmp++; if (instr_addr_o !== 32'h200 || instr_req_o !== 1'b0) begin nfail++; $display("FAIL disc_br: addr %h req %0b want 200 0", instr_addr_o, instr_req_o); end
    advance();
    branch_i = 1'b0; rv_hold = 1'b0; settle();
    ncmp++; if (instr_req_o !== 1'b0 || valid_o !== 1'b0) begin nfail++; $display("FAIL disc_old1: req %0b valid %0b want 0 0", instr_req_o, valid_o); end
    advance();
    settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin nfail++; $display("FAIL disc_reissue: req %0b addr %h want 1 200", instr_req_o, instr_addr_o); end
    ncmp++; if (valid_o !== 1'b0) begin nfail++; $display("FAIL disc_stale1: valid %0b want 0", valid_o); end
    advance();
    settle();
    ncmp++; if (valid_o !== 1'b0 || instr_addr_o !== 32'h204) begin nfail++; $display("FAIL disc_stale2: valid %0b ia %h want 0 204", valid_o, instr_addr_o); end
    advance();
    req_i = 1'b0; settle();
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h200 || rdata_o !== dat(32'h200)) begin nfail++; $display("FAIL disc_first: valid %0b addr %h data %h want 1 200 %h", valid_o, addr_o, rdata_o, dat(32'h200)); end
    advance();
    drain();
  endtask

  task automatic test_branch_pending();
    gnt_en = 1'b0; lat = 1; ready_i = 1'b1; rv_hold = 1'b0;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h500; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h500) begin nfail++; $display("FAIL pend_ia0: req %0b addr %h want 1 500", instr_req_o, instr_addr_o); end
    advance();
    addr_i = 32'h302; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin nfail++; $display("FAIL pend_retarget: req %0b addr %h want 1 300", instr_req_o, instr_addr_o); end
    advance();
    branch_i = 1'b0; req_i = 1'b0; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin nfail++; $display("FAIL pend_hold: req %0b addr %h want 1 300", instr_req_o, instr_addr_o); end
    advance();
    req_i = 1'b1; gnt_en = 1'b1; settle();
    advance();
    settle();
    ncmp++; if (instr_addr_o !== 32'h304 || valid_o !== 1'b0) begin nfail++; $display("FAIL pend_ia1: addr %h valid %0b want 304 0", instr_addr_o, valid_o); end
    advance();
    settle();
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h302 || rdata_o !== dat(32'h300)) begin nfail++; $display("FAIL pend_w0: valid %0b addr %h data %h want 1 302 %h", valid_o, addr_o, rdata_o, dat(32'h300)); end
    advance();
    req_i = 1'b0; settle();
    ncmp++; if (addr_o !== 32'h304 || rdata_o !== dat(32'h304)) begin nfail++; $display("FAIL pend_w1: addr %h data %h want 304 %h", addr_o, rdata_o, dat(32'h304)); end
    advance();
    settle();
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h308) begin nfail++; $display("FAIL pend_w2: valid %0b addr %h want 1 308", valid_o, addr_o); end
    advance();
    drain();
  endtask

  task automatic test_branch_rvalid_pop();
    gnt_en = 1'b1; lat = 1; ready_i = 1'b1; rv_hold = 1'b0;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h600; settle();
    advance();
    branch_i = 1'b0; settle();
    ncmp++; if (instr_addr_o !== 32'h604) begin nfail++; $display("FAIL brp_ia1: got %h want 604", instr_addr_o); end
    advance();
    branch_i = 1'b1; addr_i = 32'h700; settle();
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h600 || instr_rvalid_i !== 1'b1) begin nfail++; $display("FAIL brp_setup: valid %0b addr %h rvalid %0b want 1 600 1", valid_o, addr_o, instr_rvalid_i); end
    ncmp++; if (instr_addr_o !== 32'h700 || instr_req_o !== 1'b1) begin nfail++; $display("FAIL brp_ia_br: addr %h req %0b want 700 1", instr_addr_o, instr_req_o); end
    advance();
    branch_i = 1'b0; req_i = 1'b0; settle();
    ncmp++; if (valid_o !== 1'b0) begin nfail++; $display("FAIL brp_cleared: valid %0b want 0", valid_o); end
    advance();
    settle();
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h700 || rdata_o !== dat(32'h700)) begin nfail++; $display("FAIL brp_new: valid %0b addr %h data %h want 1 700 %h", valid_o, addr_o, rdata_o, dat(32'h700)); end
    advance();
    drain();
  endtask

  task automatic test_branch_gnt();
    gnt_en = 1'b1; lat = 2; ready_i = 1'b1; rv_hold = 1'b0;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h800; settle();
    advance();
    addr_i = 32'h900; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h900) begin nfail++; $display("FAIL bg_ia: req %0b addr %h want 1 900", instr_req_o, instr_addr_o); end
    advance();
    branch_i = 1'b0; req_i = 1'b0; settle();
    ncmp++; if (valid_o !== 1'b0) begin nfail++; $display("FAIL bg_old_dropped_c2: valid %0b want 0", valid_o); end
    advance();
    settle();
    ncmp++; if (valid_o !== 1'b0) begin nfail++; $display("FAIL bg_old_dropped_c3: valid %0b want 0", valid_o); end
    advance();
    settle();
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'h900 || rdata_o !== dat(32'h900)) begin nfail++; $display("FAIL bg_live: valid %0b addr %h data %h want 1 900 %h", valid_o, addr_o, rdata_o, dat(32'h900)); end
    advance();
    lat = 1;
    drain();
  endtask

  task automatic test_wrap();
    gnt_en = 1'b1; lat = 1; ready_i = 1'b1; rv_hold = 1'b0;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'hFFFF_FFFC; settle();
    ncmp++; if (instr_addr_o !== 32'hFFFF_FFFC) begin nfail++; $display("FAIL wrap_ia0: got %h want fffffffc", instr_addr_o); end
    advance();
    branch_i = 1'b0; settle();
    ncmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin nfail++; $display("FAIL wrap_ia1: req %0b addr %h want 1 0", instr_req_o, instr_addr_o); end
    advance();
    req_i = 1'b0; settle();
    ncmp++; if (valid_o !== 1'b1 || addr_o !== 32'hFFFF_FFFC) begin nfail++; $display("FAIL wrap_w0: valid %0b addr %h want 1 fffffffc", valid_o, addr_o); end
    advance();
    settle();
    ncmp++; if (addr_o !== 32'h0 || rdata_o !== dat(32'h0)) begin nfail++; $display("FAIL wrap_w1: addr %h data %h want 0 %h", addr_o, rdata_o, dat(32'h0)); end
    advance();
    drain();
  endtask

  task automatic test_reset_mid();
    gnt_en = 1'b1; lat = 1; ready_i = 1'b0; rv_hold = 1'b0;
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'hA00; settle();
    advance();
    branch_i = 1'b0; settle();
    advance();
    settle();
    ncmp++; if (valid_o !== 1'b1 || busy_o !== 1'b1) begin nfail++; $display("FAIL rmid_pre: valid %0b busy %0b want 1 1", valid_o, busy_o); end
    advance();
    rst_i = 1'b1; rv_hold = 1'b1; settle();
    ncmp++; if (valid_o !== 1'b0 || addr_o !== 32'h0 || rdata_o !== 32'h0) begin nfail++; $display("FAIL rmid_head: valid %0b addr %h data %h want 0 0 0", valid_o, addr_o, rdata_o); end
    ncmp++; if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0 || busy_o !== 1'b0) begin nfail++; $display("FAIL rmid_mem: req %0b addr %h busy %0b want 0 0 0", instr_req_o, instr_addr_o, busy_o); end
    do_reset();
  endtask

  initial begin
    ncmp = 0; nfail = 0; cyc = 0; grants = 0; lat = 1;
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; ready_i = 1'b0;
    gnt_en = 1'b0; rv_hold = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_discard();
    test_branch_pending();
    test_branch_rvalid_pop();
    test_branch_gnt();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
